sap_alu_datapath: RTL
=====================

// Module: sap_alu_datapath
// PURPOSE
//  - Accumulator (A), B register, ALU, flag register and output latch of the 8-bit SAP machine.
//  - Consumes decoded strobes from the control-unit FSM; drives the common bus when enabled.
//  - Returns flag_reg {Z,C} to the control unit for JMPZ/JMPC; sits directly downstream of it.
// PARAMETERS
//  - DW       8  data/bus width in bits
// PORTS
//  clk       in   1   system clock; all state captured on posedge
//  rst       in   1   asynchronous, active-low reset
//  bus_in    in   DW  common bus value seen by loads
//  a_load    in   1   A <- bus_in
//  a_out     in   1   drive A onto bus
//  b_load    in   1   B <- bus_in
//  alu_op    in   2   00 ADD A+B, 01 SUB A-B, 10 INC A+1, 11 DEC A-1
//  alu_wr    in   1   A <- ALU result; flags updated
//  alu_out   in   1   drive ALU result onto bus
//  o_load    in   1   OUT <- bus_in
//  bus_out   out  DW  value driven toward bus
//  bus_oe    out  1   bus_out valid/enabled
//  flag_reg  out  2   [1]=Z, [0]=C
//  out_port  out  DW  output-register contents
//  acc       out  DW  A contents (observability)
//  bus_conflict out 1 sticky: a_out and alu_out asserted together
// BEHAVIOUR
//  - Reset (rst=0, async): A, B, OUT, flag_reg, bus_conflict = 0; bus_oe = 0; bus_out = 0.
//  - Control unit changes strobes on negedge; this block samples on posedge (half-cycle setup).
//  - ALU combinational from A, B, alu_op; result width DW, carry = bit DW of DW+1-bit sum.
//    ADD: {C,R}=A+B.  SUB: {C,R}=A+~B+1 (C=1 means no borrow, A>=B).
//    INC: {C,R}=A+1 (C=1 only from FF).  DEC: {C,R}=A+{DW{1}} (C=0 only from 00).
//  - alu_wr: A<=R, Z<=(R==0), C<=carry on same posedge; flags otherwise hold.
//  - Flags change ONLY on alu_wr; a_load/b_load never alter flags.
//  - flag_reg registered; stable before next negedge so CU branch decision sees new flags.
//  - A write priority: alu_wr over a_load when both set (A<=R, flags updated).
//  - b_load and A write in same cycle: both capture; ALU uses pre-edge A and B.
//  - Bus drive (combinational): alu_out -> bus_out=R, bus_oe=1; else a_out -> bus_out=A,
//    bus_oe=1; else bus_out=0, bus_oe=0. alu_out wins over a_out.
//  - a_out & alu_out in same cycle: bus_conflict<=1 at posedge, held until reset.
//  - a_load with a_out same cycle: A reloads bus_in (no combinational loop inside block).
//  - Wrap-around: ADD FF+01 -> A=00, Z=1, C=1; DEC 00 -> A=FF, Z=0, C=0.
//  - Reset mid-instruction: all state cleared immediately, independent of clk.
// CONFIGURATION
//  - SAP_ALU_OVF_EN defined: extra output port ovf (1b), registered with flags on alu_wr;
//    signed overflow = (A[DW-1]==opB[DW-1]) && (R[DW-1]!=A[DW-1]), opB = B, ~B, 1, or all-ones
//    per alu_op; reset 0.
//  - Undefined: no ovf port, no overflow logic; all other behaviour identical.
// STRUCTURE
//  - Package sap_pkg: DW default, alu_op encodings (ALU_ADD/SUB/INC/DEC), flag bit
//    indices (FLAG_Z=1, FLAG_C=0), shared with control unit.
//  - Sub-module sap_alu: purely combinational, inputs A, B, alu_op; outputs R, carry (ovf).
//  - Top holds A/B/OUT/flag/conflict registers and bus mux.
// TESTING
//  - Reset: drive strobes randomly, pulse rst=0 between edges -> all outputs 0 immediately.
//  - ADD: a_load 05, b_load 03, alu_wr op=00 -> acc=08, flag_reg=00; alu_out -> bus_out=08.
//  - SUB equal: A=07, B=07, op=01, alu_wr -> acc=00, flag_reg=11 (Z=1, C=1).
//  - SUB borrow: A=03, B=05, op=01 -> acc=FE, flag_reg=00. INC from FF -> acc=00, flag_reg=11.
//  - Priority/conflict: a_load(bus=AA)+alu_wr(op=10, A=10) -> acc=11; a_out+alu_out ->
//    bus_out=ALU result, bus_conflict=1 sticky until rst.
//  - OUT/flags hold: o_load bus=5A -> out_port=5A, flag_reg unchanged; with SAP_ALU_OVF_EN
//    A=7F, op=10 -> acc=80, ovf=1.

Source files
------------

// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared SAP widths, ALU opcodes and flag bit positions
package sap_pkg;
    localparam int DW = 8;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_INC = 2'b10,
        ALU_DEC = 2'b11
    } alu_op_e;

    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;
endpackage

// File: rtl/sap_alu.sv
// rtl/sap_alu.sv - combinational SAP ALU; SAP_ALU_OVF_EN adds the signed-overflow output
module sap_alu
    import sap_pkg::*;
#(
    parameter int W = DW
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [1:0]   op_i,
    output logic [W-1:0] r_o,
    output logic         carry_o
`ifdef SAP_ALU_OVF_EN
    ,
    output logic         ovf_o
`endif
);
    logic [W-1:0] opb;
    logic         cin;
    logic [W:0]   sum;

    // Every op is A + opB + cin, so carry is always the top bit of one adder
    always_comb begin
        opb = b_i;
        cin = 1'b0;
        case (alu_op_e'(op_i))
            ALU_ADD: begin opb = b_i;                  cin = 1'b0; end
            ALU_SUB: begin opb = ~b_i;                 cin = 1'b1; end
            ALU_INC: begin opb = {{(W-1){1'b0}}, 1'b1}; cin = 1'b0; end
            ALU_DEC: begin opb = {W{1'b1}};            cin = 1'b0; end
            default: begin opb = b_i;                  cin = 1'b0; end
        endcase
    end

    assign sum     = {1'b0, a_i} + {1'b0, opb} + {{W{1'b0}}, cin};
    assign r_o     = sum[W-1:0];
    assign carry_o = sum[W];

`ifdef SAP_ALU_OVF_EN
    assign ovf_o = (a_i[W-1] == opb[W-1]) && (sum[W-1] != a_i[W-1]);
`endif
endmodule

// File: rtl/sap_alu_datapath.sv
// rtl/sap_alu_datapath.sv - SAP A/B/OUT/flag registers and bus driver; SAP_ALU_OVF_EN adds ovf
module sap_alu_datapath
    import sap_pkg::*;
#(
    parameter int W = DW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] bus_in,
    input  logic         a_load,
    input  logic         a_out,
    input  logic         b_load,
    input  logic [1:0]   alu_op,
    input  logic         alu_wr,
    input  logic         alu_out,
    input  logic         o_load,
    output logic [W-1:0] bus_out,
    output logic         bus_oe,
    output logic [1:0]   flag_reg,
    output logic [W-1:0] out_port,
    output logic [W-1:0] acc,
`ifdef SAP_ALU_OVF_EN
    output logic         ovf,
`endif
    output logic         bus_conflict
);
    logic [W-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
    logic [1:0]   flag_q, flag_d;
    logic         conflict_q, conflict_d;
    logic [W-1:0] alu_r;
    logic         alu_c;
`ifdef SAP_ALU_OVF_EN
    logic         alu_v;
    logic         ovf_q, ovf_d;
`endif

    sap_alu #(.W(W)) u_alu (
        .a_i     (a_q),
        .b_i     (b_q),
        .op_i    (alu_op),
        .r_o     (alu_r),
        .carry_o (alu_c)
`ifdef SAP_ALU_OVF_EN
        ,
        .ovf_o   (alu_v)
`endif
    );

    // ALU write-back outranks a bus load into A; flags move only with write-back
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        out_d      = out_q;
        flag_d     = flag_q;
        conflict_d = conflict_q | (a_out & alu_out);
`ifdef SAP_ALU_OVF_EN
        ovf_d      = ovf_q;
`endif
        if (alu_wr) begin
            a_d            = alu_r;
            flag_d[FLAG_Z] = (alu_r == '0);
            flag_d[FLAG_C] = alu_c;
`ifdef SAP_ALU_OVF_EN
            ovf_d          = alu_v;
`endif
        end else if (a_load) begin
            a_d = bus_in;
        end
        if (b_load) b_d = bus_in;
        if (o_load) out_d = bus_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q        <= '0;
            b_q        <= '0;
            out_q      <= '0;
            flag_q     <= '0;
            conflict_q <= 1'b0;
`ifdef SAP_ALU_OVF_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            out_q      <= out_d;
            flag_q     <= flag_d;
            conflict_q <= conflict_d;
`ifdef SAP_ALU_OVF_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    // Bus is released while reset is held, whatever the strobes are doing
    always_comb begin
        bus_out = '0;
        bus_oe  = 1'b0;
        if (rst) begin
            if (alu_out) begin
                bus_out = alu_r;
                bus_oe  = 1'b1;
            end else if (a_out) begin
                bus_out = a_q;
                bus_oe  = 1'b1;
            end
        end
    end

    assign flag_reg     = flag_q;
    assign out_port     = out_q;
    assign acc          = a_q;
    assign bus_conflict = conflict_q;
`ifdef SAP_ALU_OVF_EN
    assign ovf          = ovf_q;
`endif
endmodule
